hub75_frame_buffer: RTL and testbench
=====================================

Name: hub75_frame_buffer

Overview:
Parametrised, optionally double-buffered bit-plane framebuffer for HUB75 LED matrix chains. It is the successor to the fixed RGB565 / 8-panel memory block, generalised in panel width, row count and per-channel colour depth. A host port writes and reads packed pixels into the back buffer. A display port streams one bit plane of upper-half and lower-half pixels in parallel from the front buffer. Buffer swaps are applied only at display frame boundaries. The block sits between the AXI/APB pixel bridge and the scan/PWM controller.

Parameters:
COLS, 512, pixel columns across the chain; power of 2.
ROWS, 64, total panel rows; power of 2; upper half is rows 0..ROWS/2-1.
RB, 5, red bits per pixel.
GB, 6, green bits per pixel.
BB, 5, blue bits per pixel.
PLANES, 8, number of display bit planes; must be >= max(RB,GB,BB).
Derived: CW=clog2(COLS); RW=clog2(ROWS); PW=RB+GB+BB; PLW=clog2(PLANES).

Ports:
clk  in  1  system clock; all logic is synchronous to clk.
resetn  in  1  reset, asynchronous, active-low.
wr_en  in  1  host write strobe.
rd_en  in  1  host read strobe.
addr  in  RW+CW  host pixel address {row, col}.
wr_data  in  PW  packed pixel {B,G,R}, R in the LSBs.
rd_data  out  PW  host read data.
rd_valid  out  1  one-cycle pulse qualifying rd_data.
disp_rd_en  in  1  display fetch strobe.
disp_addr  in  RW-1+CW  {row within half, col}.
disp_plane  in  PLW  bit plane to output.
r0,g0,b0  out  1 each  upper-half pixel bits.
r1,g1,b1  out  1 each  lower-half pixel bits.
swap_req  in  1  request front/back swap (pulse).
frame_sync  in  1  frame-boundary pulse from the scan controller.
swap_pending  out  1  a swap is queued.
swap_done  out  1  one-cycle pulse when the swap takes effect.
front_sel  out  1  index of the current front buffer.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, r0..b1=0, swap_pending=0, swap_done=0, front_sel=0.
- Storage:
  - One 1-bit plane RAM per colour bit, per half: 2*PW RAMs.
  - Each RAM depth is (ROWS/2)*COLS*NBUF; NBUF=2 if double-buffered, else 1.
  - The buffer index is the RAM address MSB.
  - addr[RW+CW-1] selects the half.
- Host write: when wr_en=1, write all PW bits to the back buffer (~front_sel) of the addressed half in the same cycle.
- Host read:
  - rd_en=1 with wr_en=0 reads the back buffer.
  - Fixed latency 2: RAM read in cycle N+1, rd_data registered and rd_valid=1 in cycle N+2.
  - rd_data holds its value between reads.
  - Reads may be issued back-to-back, one per cycle, fully pipelined.
- wr_en and rd_en in the same cycle: the write is performed, the read is dropped, and no rd_valid is produced.
- Display read:
  - disp_rd_en=1 samples disp_addr and disp_plane; the front buffer is read.
  - r0..b1 update in cycle N+1 and hold while disp_rd_en=0.
  - disp_plane is pipelined with the address so that the outputs are aligned.
- Plane mapping is MSB-aligned. For a channel of width W and plane p, bit index = p-(PLANES-W).
  - If that index is negative, the output is 0.
  - Example with PLANES=8, R=5: p=3 gives R[0]; p=7 gives R[4]; p<3 gives 0.
- Swap handshake:
  - swap_req=1 sets swap_pending.
  - On a cycle with frame_sync=1 and (swap_pending=1 or swap_req=1): front_sel toggles and swap_pending clears on the next edge; swap_done pulses in that same next cycle.
  - swap_req while already pending has no additional effect; exactly one swap occurs.
  - frame_sync with nothing pending: no change.
- The front_sel flip applies to accesses issued from the cycle after the edge. In-flight reads complete from the buffer that was addressed at issue.
- Reset mid-operation: all pipeline state clears, a pending swap is lost, and front_sel returns to 0. RAM contents are undefined after reset and are not cleared.

Optional Feature:
HUB75_DOUBLE_BUFFER_EN
- Defined: NBUF=2 and the swap logic is as described above.
- Undefined:
  - NBUF=1; host and display share a single buffer.
  - swap_req and frame_sync are ignored.
  - swap_pending, swap_done and front_sel are tied to 0.
  - RAM depth is halved.

Decomposition:
- Package hub75_pkg:
  - Default COLS/ROWS/RB/GB/BB/PLANES.
  - Pixel field offsets: R_LSB=0, G_LSB=RB, B_LSB=RB+GB.
  - A plane-to-bit index function.
- Sub-module hub75_plane_ram:
  - Simple dual-port 1-bit RAM, parameter DEPTH.
  - Port A: write/read, sync read latency 1.
  - Port B: sync read latency 1.
  - Instantiated 2*PW times via generate.

Test Plan:
- Write 0xF81F to addr {row 5, col 10}; rd_en at cycle N → rd_valid=1 and rd_data=0xF81F at N+2; a read of the lower half at {row 37, col 10} returns the prior content.
- Write R=5'b10001, G=0, B=0 at row 0 col 0 in the back buffer, then swap; disp reads with plane 7 → r0=1; plane 3 → r0=1; plane 4 → r0=0; plane 2 → r0=0; g0=b0=0 throughout.
- swap_req at cycle 10, frame_sync at cycle 20 → swap_pending=1 on cycles 11–20, front_sel=1 and swap_done=1 at cycle 21; a second frame_sync produces no change.
- swap_req and frame_sync in the same cycle → front_sel toggles on the next edge; swap_pending never asserts.
- wr_en=rd_en=1 with 0x1234 → no rd_valid; a subsequent read returns 0x1234.
- resetn deasserted while swap_pending=1 and a read is in flight → all outputs 0, front_sel=0, no rd_valid after release; repeat with HUB75_DOUBLE_BUFFER_EN undefined and confirm a host write is visible on the display port immediately.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 bit-plane framebuffer.
// Holds the default geometry / colour depth, the packed-pixel field
// offsets ({B,G,R}, R in the LSBs) and the plane-to-bit mapping helper.
package hub75_pkg;

  localparam int DEF_COLS   = 512;
  localparam int DEF_ROWS   = 64;
  localparam int DEF_RB     = 5;
  localparam int DEF_GB     = 6;
  localparam int DEF_BB     = 5;
  localparam int DEF_PLANES = 8;

  localparam int R_LSB = 0;
  localparam int G_LSB = DEF_RB;
  localparam int B_LSB = DEF_RB + DEF_GB;

  // MSB-aligned plane mapping: the top plane always shows the channel MSB,
  // narrower channels run out of bits at low planes (negative result).
  function automatic int plane_bit(input int plane, input int width, input int planes);
    return plane - (planes - width);
  endfunction

endpackage

// File: rtl/hub75_plane_ram.sv
// 1-bit simple dual-port plane RAM.
//   clk                 : clock
//   a_en/a_we/a_addr    : port A enable, write enable, address
//   a_din/a_dout        : port A write data / read data (read-first, latency 1)
//   b_en/b_addr/b_dout  : port B read-only, latency 1
// Read registers only load when their port is enabled, so data holds
// between accesses. Contents are not reset.
module hub75_plane_ram #(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          a_en,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic          a_din,
  output logic          a_dout,
  input  logic          b_en,
  input  logic [AW-1:0] b_addr,
  output logic          b_dout
);

  logic mem [DEPTH];

  always_ff @(posedge clk) begin
    if (a_en) begin
      if (a_we) mem[a_addr] <= a_din;
      a_dout <= mem[a_addr];
    end
    if (b_en) b_dout <= mem[b_addr];
  end

endmodule

// File: rtl/hub75_frame_buffer.sv
// HUB75 bit-plane framebuffer, optionally double-buffered.
// Build option: HUB75_DOUBLE_BUFFER_EN (two buffers + frame-synchronous
// swap); without it a single buffer is shared by host and display.
// Ports:
//   clk, resetn                 : clock, async active-low reset
//   wr_en, rd_en, addr, wr_data : host access to the back buffer ({row,col})
//   rd_data, rd_valid           : host read result, latency 2
//   disp_rd_en, disp_addr,
//   disp_plane                  : display fetch ({row in half, col}, plane)
//   r0,g0,b0 / r1,g1,b1         : upper / lower half plane bits, latency 1
//   swap_req, frame_sync        : swap request / frame boundary
//   swap_pending, swap_done,
//   front_sel                   : swap status
module hub75_frame_buffer
  import hub75_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int RB     = DEF_RB,
  parameter int GB     = DEF_GB,
  parameter int BB     = DEF_BB,
  parameter int PLANES = DEF_PLANES,
  localparam int CW    = $clog2(COLS),
  localparam int RW    = $clog2(ROWS),
  localparam int PW    = RB + GB + BB,
  localparam int PLW   = $clog2(PLANES)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [RW+CW-1:0] addr,
  input  logic [PW-1:0]    wr_data,
  output logic [PW-1:0]    rd_data,
  output logic             rd_valid,
  input  logic             disp_rd_en,
  input  logic [RW+CW-2:0] disp_addr,
  input  logic [PLW-1:0]   disp_plane,
  output logic             r0,
  output logic             g0,
  output logic             b0,
  output logic             r1,
  output logic             g1,
  output logic             b1,
  input  logic             swap_req,
  input  logic             frame_sync,
  output logic             swap_pending,
  output logic             swap_done,
  output logic             front_sel
);

`ifdef HUB75_DOUBLE_BUFFER_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif
  localparam int HALF_AW = RW - 1 + CW;
  localparam int DEPTH   = (ROWS / 2) * COLS * NBUF;
  localparam int AW      = $clog2(DEPTH);
  localparam int R_OFF   = R_LSB;
  localparam int G_OFF   = R_LSB + RB;
  localparam int B_OFF   = R_LSB + RB + GB;

  logic [AW-1:0]        a_addr, b_addr;
  logic [1:0][PW-1:0]   q_a, q_b;
  logic                 host_rd, half_sel;

  assign host_rd  = rd_en & ~wr_en;   // a colliding write wins, read is dropped
  assign half_sel = addr[RW+CW-1];

  // ---------------- swap control / buffer addressing ----------------
`ifdef HUB75_DOUBLE_BUFFER_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
      front_sel    <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      if (frame_sync && (swap_pending || swap_req)) begin
        front_sel    <= ~front_sel;
        swap_pending <= 1'b0;
        swap_done    <= 1'b1;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // Buffer index is the RAM address MSB; host owns the back, display the front.
  assign a_addr = {~front_sel, addr[HALF_AW-1:0]};
  assign b_addr = {front_sel, disp_addr};
`else
  logic unused_swap;
  assign unused_swap  = swap_req ^ frame_sync;
  assign swap_pending = 1'b0;
  assign swap_done    = 1'b0;
  assign front_sel    = 1'b0;
  assign a_addr       = addr[HALF_AW-1:0];
  assign b_addr       = disp_addr;
`endif

  // ---------------- plane RAM array: [half][colour bit] ----------------
  for (genvar h = 0; h < 2; h++) begin : g_half
    for (genvar b = 0; b < PW; b++) begin : g_bit
      hub75_plane_ram #(.DEPTH(DEPTH)) u_ram (
        .clk    (clk),
        .a_en   (wr_en | rd_en),
        .a_we   (wr_en && (half_sel == 1'(h))),
        .a_addr (a_addr),
        .a_din  (wr_data[b]),
        .a_dout (q_a[h][b]),
        .b_en   (disp_rd_en),
        .b_addr (b_addr),
        .b_dout (q_b[h][b])
      );
    end
  end

  // ---------------- host read pipeline ----------------
  logic [2:1] vld_pipe;
  logic       half_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
      half_q   <= 1'b0;
      rd_data  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], host_rd};
      if (host_rd)     half_q  <= half_sel;
      if (vld_pipe[1]) rd_data <= q_a[half_q];
    end
  end

  assign rd_valid = vld_pipe[2];

  // ---------------- display path ----------------
  // plane_q travels alongside the RAM read so outputs stay aligned;
  // disp_vld masks the unreset RAM output registers until the first fetch.
  logic           disp_vld;
  logic [PLW-1:0] plane_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      disp_vld <= 1'b0;
      plane_q  <= '0;
    end else if (disp_rd_en) begin
      disp_vld <= 1'b1;
      plane_q  <= disp_plane;
    end
  end

  function automatic logic chan_bit(input logic [PW-1:0] px, input int off,
                                    input int w, input int idx);
    logic v;
    v = 1'b0;
    for (int i = 0; i < PW; i++)
      if (i >= off && i < off + w && (i - off) == idx) v = px[i];
    return v;
  endfunction

  always_comb begin
    {r0, g0, b0, r1, g1, b1} = '0;
    if (disp_vld) begin
      r0 = chan_bit(q_b[0], R_OFF, RB, plane_bit(int'(plane_q), RB, PLANES));
      g0 = chan_bit(q_b[0], G_OFF, GB, plane_bit(int'(plane_q), GB, PLANES));
      b0 = chan_bit(q_b[0], B_OFF, BB, plane_bit(int'(plane_q), BB, PLANES));
      r1 = chan_bit(q_b[1], R_OFF, RB, plane_bit(int'(plane_q), RB, PLANES));
      g1 = chan_bit(q_b[1], G_OFF, GB, plane_bit(int'(plane_q), GB, PLANES));
      b1 = chan_bit(q_b[1], B_OFF, BB, plane_bit(int'(plane_q), BB, PLANES));
    end
  end

endmodule

// File: tb/tb_hub75_frame_buffer.sv
// Scoreboard bench for hub75_frame_buffer (small geometry: 16 cols x 64 rows).
// Stimulus pushes expected responses with the cycle they are due; the
// negedge monitor pops and compares host reads, display bits and swap status.
module tb_hub75_frame_buffer;

  localparam int COLS = 16, ROWS = 64, RB = 5, GB = 6, BB = 5, PLANES = 8;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        wr_en, rd_en, disp_rd_en, swap_req, frame_sync;
  logic [9:0]  addr;
  logic [15:0] wr_data, rd_data;
  logic        rd_valid;
  logic [8:0]  disp_addr;
  logic [2:0]  disp_plane;
  logic        r0, g0, b0, r1, g1, b1;
  logic        swap_pending, swap_done, front_sel;

  hub75_frame_buffer #(
    .COLS(COLS), .ROWS(ROWS), .RB(RB), .GB(GB), .BB(BB), .PLANES(PLANES)
  ) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .disp_rd_en(disp_rd_en), .disp_addr(disp_addr), .disp_plane(disp_plane),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .swap_req(swap_req), .frame_sync(frame_sync), .swap_pending(swap_pending),
    .swap_done(swap_done), .front_sel(front_sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [15:0] d; } rd_t;
  typedef struct { int due; logic [5:0] v; } dp_t;   // {r0,g0,b0,r1,g1,b1}
  typedef struct { int due; logic [2:0] s; bit chk_rd; logic [15:0] rd; } st_t; // s={pending,done,front}

  rd_t rq[$];
  dp_t dq[$];
  st_t sq[$];
  rd_t re;
  dp_t de;
  st_t se;
  int checks = 0, errors = 0;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rd_valid) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: cyc %0d got rd_valid=1 data=%h, required no rd_valid", cyc, rd_data);
      end else begin
        re = rq.pop_front();
        if (re.due != cyc || rd_data !== re.d) begin
          errors++;
          $display("FAIL rd_data: cyc %0d got %h, required %h at cyc %0d", cyc, rd_data, re.d, re.due);
        end
      end
    end else if (rq.size() > 0 && rq[0].due <= cyc) begin
      checks++; errors++;
      re = rq.pop_front();
      $display("FAIL rd_missing: cyc %0d got rd_valid=0, required data %h", cyc, re.d);
    end
    while (dq.size() > 0 && dq[0].due <= cyc) begin
      de = dq.pop_front();
      checks++;
      if (de.due != cyc || {r0, g0, b0, r1, g1, b1} !== de.v) begin
        errors++;
        $display("FAIL disp_bits: cyc %0d got %b, required %b", cyc, {r0, g0, b0, r1, g1, b1}, de.v);
      end
    end
    while (sq.size() > 0 && sq[0].due <= cyc) begin
      se = sq.pop_front();
      checks++;
      if (se.due != cyc || {swap_pending, swap_done, front_sel} !== se.s ||
          (se.chk_rd && rd_data !== se.rd)) begin
        errors++;
        $display("FAIL status: cyc %0d got pend/done/front=%b rd_data=%h, required %b rd_data=%h",
                 cyc, {swap_pending, swap_done, front_sel}, rd_data, se.s, se.rd);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(); @(posedge clk); #1; endtask

  task automatic idle();
    wr_en = 0; rd_en = 0; disp_rd_en = 0; swap_req = 0; frame_sync = 0;
  endtask

  function automatic logic [9:0] pa(input int row, input int col);
    return 10'(row * COLS + col);
  endfunction

  task automatic hwrite(input logic [9:0] a, input logic [15:0] d);
    idle(); wr_en = 1; addr = a; wr_data = d; step(); idle();
  endtask

  task automatic hread(input logic [9:0] a, input logic [15:0] exp_d);
    rd_t e;
    idle(); rd_en = 1; addr = a;
    e.due = cyc + 2; e.d = exp_d; rq.push_back(e);
    step(); idle();
  endtask

  task automatic dread(input logic [8:0] a, input logic [2:0] p, input logic [5:0] exp_v);
    dp_t e;
    idle(); disp_rd_en = 1; disp_addr = a; disp_plane = p;
    e.due = cyc + 1; e.v = exp_v; dq.push_back(e);
    step(); idle();
  endtask

  task automatic expect_st(input logic [2:0] s, input bit chk_rd, input logic [15:0] rd);
    st_t e;
    e.due = cyc; e.s = s; e.chk_rd = chk_rd; e.rd = rd; sq.push_back(e);
  endtask

  task automatic expect_dp(input logic [5:0] v);
    dp_t e;
    e.due = cyc; e.v = v; dq.push_back(e);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle(); addr = '0; wr_data = '0; disp_addr = '0; disp_plane = '0;
    resetn = 0;
    repeat (3) step();
    expect_st(3'b000, 1, 16'h0000); expect_dp(6'b000000);
    resetn = 1; step();
    expect_st(3'b000, 1, 16'h0000); expect_dp(6'b000000);

    // host write/read, half select, back-to-back reads
    hwrite(pa(37, 10), 16'h07E0);
    hwrite(pa(5, 10),  16'hF81F);
    hread(pa(5, 10),  16'hF81F);
    hread(pa(37, 10), 16'h07E0);
    repeat (3) step();

    // write+read collision: write lands, read dropped
    idle(); wr_en = 1; rd_en = 1; addr = pa(12, 3); wr_data = 16'h1234;
    step(); idle(); step();
    hread(pa(12, 3), 16'h1234);
    repeat (3) step();

`ifdef HUB75_DOUBLE_BUFFER_EN
    // swap_req then frame_sync ten cycles later, redundant request in between
    swap_req = 1; step(); swap_req = 0;
    for (int i = 1; i <= 10; i++) begin
      expect_st(3'b100, 0, '0);
      if (i == 5)  swap_req = 1;
      if (i == 10) frame_sync = 1;
      step(); swap_req = 0; frame_sync = 0;
    end
    expect_st(3'b011, 0, '0); step();
    expect_st(3'b001, 0, '0);
    frame_sync = 1; step(); frame_sync = 0;   // nothing pending: no change
    expect_st(3'b001, 0, '0); step();
    expect_st(3'b001, 0, '0);
`endif

    // display plane mapping: upper {B,G,R}=R 10001, lower B=11111 G=100000
    hwrite(pa(0, 0),  16'h0011);
    hwrite(pa(32, 0), 16'hFC00);
    swap_req = 1; frame_sync = 1; step(); idle();
`ifdef HUB75_DOUBLE_BUFFER_EN
    expect_st(3'b010, 0, '0); step();         // front 1 -> 0, never pending
    expect_st(3'b000, 0, '0);
`else
    expect_st(3'b000, 0, '0); step();
    expect_st(3'b000, 0, '0);
`endif
    dread(9'd0, 3'd2, 6'b000000);
    dread(9'd0, 3'd4, 6'b000001);
    dread(9'd0, 3'd3, 6'b100001);
    dread(9'd0, 3'd7, 6'b100011);
    step(); step();
    expect_dp(6'b100011);                     // outputs hold while idle
    step();

    // reset while a swap is pending and a read is in flight
`ifdef HUB75_DOUBLE_BUFFER_EN
    swap_req = 1; step(); swap_req = 0;
    expect_st(3'b100, 0, '0);
`endif
    idle(); rd_en = 1; addr = pa(5, 10); step(); idle();
    resetn = 0;
    expect_st(3'b000, 1, 16'h0000); expect_dp(6'b000000);
    step(); step();
    resetn = 1; step();
    expect_st(3'b000, 1, 16'h0000); expect_dp(6'b000000);
    frame_sync = 1; step(); frame_sync = 0;   // the lost swap must not happen
    expect_st(3'b000, 1, 16'h0000);
    step();

`ifndef HUB75_DOUBLE_BUFFER_EN
    // single buffer: a host write is seen by the display straight away
    hwrite(pa(1, 3), 16'h0010);
    dread(9'(1 * COLS + 3), 3'd7, 6'b100000);
    step();
`endif

    repeat (6) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
